// File: rtl/secuencia_param_if.sv
// Serial sample/flag bundle for the parametrised sequence detector.
// The master drives the sample strobe, data bit and count clear; the slave returns the flag and count.
interface secuencia_param_if #(
   parameter int CNT_W = 8
) ();
   logic             en;
   logic             w;
   logic             clear;
   logic             z;
   logic [CNT_W-1:0] count;

   modport master (output en, output w, output clear, input z, input count);
   modport slave  (input en, input w, input clear, output z, output count);
endinterface

// File: rtl/secuencia_param.sv
// Parametrised serial pattern detector with Mealy/Moore output, optional overlap and a saturating match counter.
// hist keeps the last LEN-1 accepted bits; fill gates matching until enough fresh bits have arrived.
module secuencia_param #(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter int             MOORE   = 0,
   parameter int             OVERLAP = 1,
   parameter int             CNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   secuencia_param_if.slave  bus
);
   localparam int           FW       = $clog2(LEN);
   localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

   if (LEN < 2 || LEN > 16) begin : g_len_bad
      $error("secuencia_param: LEN must be in 2..16");
   end

   logic [LEN-2:0]   hist;
   logic [FW-1:0]    fill;
   logic [CNT_W-1:0] count;
   logic [LEN-1:0]   hist_w;
   logic [LEN-2:0]   hist_nxt;
   logic             match_now;

   // Candidate window is the stored history plus the bit on the wire this cycle.
   always_comb begin
      hist_w    = {hist, bus.w};
      hist_nxt  = hist_w[LEN-2:0];
      match_now = bus.en & (fill == FILL_MAX) & (hist_w == PATTERN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else if (bus.en) begin
         hist <= hist_nxt;
         // Non-overlap: the shifted bits stay in hist but fill marks them stale.
         if (OVERLAP == 0 && match_now)
            fill <= '0;
         else if (fill != FILL_MAX)
            fill <= fill + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear)
         count <= '0;
      else if (match_now && count != {CNT_W{1'b1}})
         count <= count + CNT_W'(1);
   end

   assign bus.count = count;

   if (MOORE != 0) begin : g_moore
      logic z_reg;
      always_ff @(posedge clk) begin
         if (reset) z_reg <= 1'b0;
         else       z_reg <= match_now;
      end
      assign bus.z = z_reg;
   end else begin : g_mealy
      assign bus.z = match_now & ~reset;
   end
endmodule

// File: tb/tb_secuencia_param.sv
// Drives five detector builds with one shared stimulus and checks them against a bit-history reference model.
module tb_secuencia_param;
   localparam int NC = 5;
   // config: 0 default, 1 no-overlap, 2 Moore, 3 CNT_W=2, 4 LEN=2 pattern 01 Moore no-overlap
   localparam int LENS[NC] = '{4, 4, 4, 4, 2};
   localparam int PATS[NC] = '{11, 11, 11, 11, 1};
   localparam int MOO [NC] = '{0, 0, 1, 0, 1};
   localparam int OVL [NC] = '{1, 0, 1, 1, 0};
   localparam int CMAX[NC] = '{255, 255, 255, 3, 255};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_t = 1'b0, w_t = 1'b0, clr_t = 1'b0;
   always #5 clk = ~clk;

   secuencia_param_if #(.CNT_W(8)) if0 ();
   secuencia_param_if #(.CNT_W(8)) if1 ();
   secuencia_param_if #(.CNT_W(8)) if2 ();
   secuencia_param_if #(.CNT_W(2)) if3 ();
   secuencia_param_if #(.CNT_W(8)) if4 ();

   assign if0.en = en_t; assign if0.w = w_t; assign if0.clear = clr_t;
   assign if1.en = en_t; assign if1.w = w_t; assign if1.clear = clr_t;
   assign if2.en = en_t; assign if2.w = w_t; assign if2.clear = clr_t;
   assign if3.en = en_t; assign if3.w = w_t; assign if3.clear = clr_t;
   assign if4.en = en_t; assign if4.w = w_t; assign if4.clear = clr_t;

   secuencia_param #(.LEN(4), .PATTERN(4'b1011), .MOORE(0), .OVERLAP(1), .CNT_W(8))
      u0 (.clk(clk), .reset(rst), .bus(if0));
   secuencia_param #(.LEN(4), .PATTERN(4'b1011), .MOORE(0), .OVERLAP(0), .CNT_W(8))
      u1 (.clk(clk), .reset(rst), .bus(if1));
   secuencia_param #(.LEN(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(1), .CNT_W(8))
      u2 (.clk(clk), .reset(rst), .bus(if2));
   secuencia_param #(.LEN(4), .PATTERN(4'b1011), .MOORE(0), .OVERLAP(1), .CNT_W(2))
      u3 (.clk(clk), .reset(rst), .bus(if3));
   secuencia_param #(.LEN(2), .PATTERN(2'b01), .MOORE(1), .OVERLAP(0), .CNT_W(8))
      u4 (.clk(clk), .reset(rst), .bus(if4));

   logic        zo[NC];
   int unsigned co[NC];
   assign zo[0] = if0.z; assign co[0] = 32'(if0.count);
   assign zo[1] = if1.z; assign co[1] = 32'(if1.count);
   assign zo[2] = if2.z; assign co[2] = 32'(if2.count);
   assign zo[3] = if3.z; assign co[3] = 32'(if3.count);
   assign zo[4] = if4.z; assign co[4] = 32'(if4.count);

   // Model: bits accepted since the last restart, the recent bits, count and the delayed flag.
   int          nval[NC];
   int unsigned last[NC];
   int unsigned cnt [NC];
   bit          zreg[NC];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs, then advance the model over the coming edge.
   task automatic step(input bit e, input bit b, input bit c, input bit r);
      bit          m;
      bit          exp_z;
      int unsigned win;
      @(negedge clk);
      en_t = e; w_t = b; clr_t = c; rst = r;
      #1;
      for (int i = 0; i < NC; i++) begin
         win   = ((last[i] << 1) | 32'(b)) & ((32'd1 << LENS[i]) - 1);
         m     = e && (nval[i] >= LENS[i] - 1) && (win == 32'(PATS[i]));
         exp_z = (MOO[i] != 0) ? zreg[i] : (m & ~r);
         checks++;
         assert (zo[i] === exp_z) else begin
            errors++;
            $error("FAIL z cfg%0d t=%0t observed %0b expected %0b", i, $time, zo[i], exp_z);
         end
         checks++;
         assert (co[i] === cnt[i]) else begin
            errors++;
            $error("FAIL count cfg%0d t=%0t observed %0d expected %0d", i, $time, co[i], cnt[i]);
         end
         if (r) begin
            nval[i] = 0; last[i] = 0; cnt[i] = 0; zreg[i] = 1'b0;
         end else begin
            zreg[i] = m;
            if (c) cnt[i] = 0;
            else if (m && cnt[i] < 32'(CMAX[i])) cnt[i]++;
            if (e) begin
               last[i] = (last[i] << 1) | 32'(b);
               nval[i]++;
               if (m && OVL[i] == 0) nval[i] = 0;
            end
         end
      end
   endtask

   task automatic feed(input logic [31:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NC; i++) begin
         nval[i] = 0; last[i] = 0; cnt[i] = 0; zreg[i] = 1'b0;
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // Reference stream 1011011: overlap gives two hits, non-overlap one.
      feed(32'b1011011, 7);
      settle();
      chk("stream cnt default", co[0], 2);
      chk("stream cnt nonovl",  co[1], 1);
      chk("stream cnt moore",   co[2], 2);
      step(0, 0, 0, 0);

      // Gaps: en low ignores the toggling w.
      step(0, 0, 0, 1);
      feed(32'b10, 2);
      step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
      feed(32'b11, 2);
      settle();
      chk("gap cnt", co[0], 1);

      // Reset in the middle of a partial pattern.
      step(0, 0, 0, 1);
      feed(32'b101, 3);
      step(1, 1, 0, 1);
      feed(32'b1, 1);
      settle();
      chk("post-reset cnt", co[0], 0);
      feed(32'b011, 3);
      feed(32'b1011, 4);

      // Saturation on the narrow counter, then clear colliding with a match.
      step(0, 0, 0, 1);
      feed(32'b1011011011011011, 16);
      settle();
      chk("sat cnt narrow", co[3], 3);
      chk("sat cnt wide",   co[0], 5);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      settle();
      chk("clear on match narrow", co[3], 0);
      chk("clear on match wide",   co[0], 0);

      // Random traffic with occasional clear and reset.
      for (int n = 0; n < 600; n++)
         step(($urandom % 4) != 0, $urandom % 2,
              ($urandom % 32) == 0, ($urandom % 64) == 0);
      step(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
